// File: rtl/feat_bram_readback_streamer.sv
// Streams the GAT new-feature BRAM out in address order after gat_ready rises.
// A tag pipeline tracks reads in flight so the prefetch FIFO can never overflow.
module feat_bram_readback_streamer #(
   parameter int NEW_FEATURE_WIDTH  = 32,
   parameter int NUM_SUBGRAPHS      = 2708,
   parameter int NUM_FEATURE_OUT    = 16,
   parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
   parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
   parameter int BRAM_RD_LATENCY    = 2,
   parameter int FIFO_DEPTH         = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          gat_ready,
   output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
   input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
   output logic [NEW_FEATURE_WIDTH-1:0]  m_tdata,
   output logic                          m_tvalid,
   input  logic                          m_tready,
   output logic                          m_tlast,
   output logic                          busy,
   output logic                          done
);

   localparam int AW = NEW_FEATURE_ADDR_W;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
   localparam int L  = BRAM_RD_LATENCY;

   localparam logic [AW-1:0] IDX_LAST = AW'(NEW_FEATURE_DEPTH - 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
   localparam logic [CW-1:0] CREDITS  = CW'(FIFO_DEPTH);

   if (BRAM_RD_LATENCY < 1) begin : g_bad_latency
      $error("BRAM_RD_LATENCY must be at least 1");
   end
   if (FIFO_DEPTH < BRAM_RD_LATENCY + 2) begin : g_bad_fifo
      $error("FIFO_DEPTH must be at least BRAM_RD_LATENCY+2");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN
   } state_t;

   state_t                 state;
   logic                   gat_ready_d;
   logic [AW-1:0]          rd_idx;
   logic [AW-1:0]          tx_idx;
   logic [L-1:0]           tag;
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic [CW-1:0]          fifo_count;
   logic [CW-1:0]          inflight;
   logic                   busy_q;
   logic                   done_q;
   logic [NEW_FEATURE_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

   logic start;
   logic issue;
   logic fifo_wr;
   logic fifo_empty;
   logic hs;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < L; i++) begin
         inflight = inflight + CW'(tag[i]);
      end
   end

   assign start      = (state == S_IDLE) & gat_ready & ~gat_ready_d;
   assign fifo_empty = (fifo_count == '0);
   assign fifo_wr    = tag[L-1];
   assign hs         = m_tvalid & m_tready;
   assign issue      = (state == S_READ) &&
                       ((inflight + fifo_count) < CREDITS);

   assign feat_bram_addrb = {rd_idx, 2'b00};
   assign m_tvalid        = ~fifo_empty;
   assign m_tdata         = fifo_empty ? '0 : fifo_mem[rd_ptr];
   assign m_tlast         = m_tvalid & (tx_idx == IDX_LAST);
   assign busy            = busy_q;
   assign done            = done_q;

   always_ff @(posedge clk) begin
      if (fifo_wr) begin
         fifo_mem[wr_ptr] <= feat_bram_dout;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         gat_ready_d <= 1'b0;
         rd_idx      <= '0;
         tx_idx      <= '0;
         tag         <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_count  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         gat_ready_d <= gat_ready;
         done_q      <= 1'b0;

         // Stage 0 holds this cycle's issue; the last stage marks dout valid.
         tag[0] <= issue;
         for (int i = 1; i < L; i++) begin
            tag[i] <= tag[i-1];
         end

         if (fifo_wr) begin
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
         end
         if (hs) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
            tx_idx <= tx_idx + AW'(1);
         end
         if (fifo_wr && !hs) begin
            fifo_count <= fifo_count + CW'(1);
         end else if (!fifo_wr && hs) begin
            fifo_count <= fifo_count - CW'(1);
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  state      <= S_READ;
                  busy_q     <= 1'b1;
                  rd_idx     <= '0;
                  tx_idx     <= '0;
                  tag        <= '0;
                  wr_ptr     <= '0;
                  rd_ptr     <= '0;
                  fifo_count <= '0;
               end
            end
            S_READ: begin
               if (issue) begin
                  if (rd_idx == IDX_LAST) begin
                     state <= S_DRAIN;
                  end else begin
                     rd_idx <= rd_idx + AW'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (hs && (tx_idx == IDX_LAST)) begin
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && fifo_wr && !hs) begin
         assert (fifo_count < CREDITS);
      end
   end

endmodule

// File: tb/tb_feat_bram_readback_streamer.sv
// Bench for feat_bram_readback_streamer: two instances (latency 2 and 1)
// share stimulus; a stream-level model checks every cycle.
module tb_feat_bram_readback_streamer;

   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic gat_ready = 1'b0;
   logic m_tready = 1'b0;

   logic [AW+1:0] addrb  [2];
   logic [31:0]   dout   [2];
   logic [31:0]   tdata  [2];
   logic          tvalid [2];
   logic          tlast  [2];
   logic          busy   [2];
   logic          done   [2];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int lat [2] = '{2, 1};
   int fd  [2] = '{4, 3};

   bit          bsy [2], dn [2], xrst [2], held [2], grd [2], stalled [2];
   int          k [2], hsn [2], ts [2], drains [2];
   logic [31:0] hd [2];
   logic        hl [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   feat_bram_readback_streamer #(
      .NEW_FEATURE_WIDTH(32), .NUM_SUBGRAPHS(2), .NUM_FEATURE_OUT(4),
      .BRAM_RD_LATENCY(2), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst), .gat_ready(gat_ready),
      .feat_bram_addrb(addrb[0]), .feat_bram_dout(dout[0]),
      .m_tdata(tdata[0]), .m_tvalid(tvalid[0]), .m_tready(m_tready),
      .m_tlast(tlast[0]), .busy(busy[0]), .done(done[0])
   );

   feat_bram_readback_streamer #(
      .NEW_FEATURE_WIDTH(32), .NUM_SUBGRAPHS(2), .NUM_FEATURE_OUT(4),
      .BRAM_RD_LATENCY(1), .FIFO_DEPTH(3)
   ) dut1 (
      .clk(clk), .rst(rst), .gat_ready(gat_ready),
      .feat_bram_addrb(addrb[1]), .feat_bram_dout(dout[1]),
      .m_tdata(tdata[1]), .m_tvalid(tvalid[1]), .m_tready(m_tready),
      .m_tlast(tlast[1]), .busy(busy[1]), .done(done[1])
   );

   // BRAM models: word index tagged with 0xA000_0000 after the read latency.
   logic [AW-1:0] p0;
   always @(posedge clk) begin
      p0      <= addrb[0][AW+1:2];
      dout[0] <= 32'hA000_0000 | 32'(p0);
      dout[1] <= 32'hA000_0000 | 32'(addrb[1][AW+1:2]);
   end

   task automatic chk(string nm, int u, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s u%0d cyc %0d: got %0h want %0h",
                  nm, u, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         bit hs, b0;
         if (xrst[u])
            chk("rst_vals", u, 32'({tvalid[u], busy[u], done[u], tlast[u]})
                | 32'(addrb[u]) | tdata[u], 32'd0);
         chk("busy", u, 32'(busy[u]), 32'(bsy[u]));
         chk("done", u, 32'(done[u]), 32'(dn[u]));
         if (held[u]) begin
            chk("hold_valid", u, 32'(tvalid[u]), 32'd1);
            chk("hold_data", u, tdata[u], hd[u]);
            chk("hold_last", u, 32'(tlast[u]), 32'(hl[u]));
         end
         if (tvalid[u]) begin
            chk("valid_in_drain", u, 32'(bsy[u]), 32'd1);
            chk("data", u, tdata[u], 32'hA000_0000 | 32'(k[u]));
            chk("last", u, 32'(tlast[u]), 32'(k[u] == DEPTH - 1));
         end else begin
            chk("last_low", u, 32'(tlast[u]), 32'd0);
         end
         if (bsy[u] && (cyc - ts[u] <= lat[u] + 2))
            chk("first_valid", u, 32'(tvalid[u]),
                32'(cyc - ts[u] == lat[u] + 2));
         if (bsy[u])
            chk("outstanding", u,
                32'(int'(addrb[u] >> 2) - hsn[u] <= fd[u]), 32'd1);

         if (rst) begin
            xrst[u] = 1; bsy[u] = 0; dn[u] = 0; k[u] = 0;
            held[u] = 0; grd[u] = 0; hsn[u] = 0;
            continue;
         end
         xrst[u] = 0;
         dn[u] = 0;
         b0 = bsy[u];
         hs = tvalid[u] & m_tready;
         if (hs) begin
            if (k[u] == DEPTH - 1) begin
               dn[u] = 1;
               bsy[u] = 0;
               if (!stalled[u])
                  chk("full_rate", u, 32'(cyc - ts[u]),
                      32'(DEPTH + lat[u] + 1));
            end
            k[u]++;
            hsn[u]++;
         end
         if (tvalid[u] && !m_tready) stalled[u] = 1;
         if (gat_ready && !grd[u] && !b0) begin
            bsy[u] = 1; ts[u] = cyc; k[u] = 0; hsn[u] = 0;
            stalled[u] = 0; drains[u]++;
         end
         grd[u] = gat_ready;
         held[u] = tvalid[u] & ~m_tready;
         hd[u] = tdata[u];
         hl[u] = tlast[u];
      end
   end

   task automatic go(int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic look(int n);
      go(n);
      @(negedge clk);
      #1;
   endtask

   task automatic wait_done(string nm, bit rnd);
      bit g0, g1;
      g0 = 0;
      g1 = 0;
      for (int n = 0; n < 400 && !(g0 && g1); n++) begin
         m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         #1;
         if (done[0]) g0 = 1;
         if (done[1]) g1 = 1;
         go(cyc + 1);
      end
      chk(nm, 0, 32'(g0), 32'd1);
      chk(nm, 1, 32'(g1), 32'd1);
   endtask

   initial begin
      int d0, d1, t;
      go(3);
      rst = 0;
      look(3);
      for (int u = 0; u < 2; u++) begin
         chk("reset_valid", u, 32'(tvalid[u]), 32'd0);
         chk("reset_busy", u, 32'(busy[u]), 32'd0);
         chk("reset_addr", u, 32'(addrb[u]), 32'd0);
      end

      // Basic drain, edge in cycle 10, ready held high.
      go(10);
      gat_ready = 1;
      m_tready = 1;
      go(11);
      gat_ready = 0;
      for (int c = 11; c <= 22; c++) begin
         look(c);
         for (int u = 0; u < 2; u++) begin
            bit v;
            v = (c >= 12 + lat[u]) && (c <= 19 + lat[u]);
            chk("b_valid", u, 32'(tvalid[u]), 32'(v));
            chk("b_addr", u, 32'(addrb[u]), c <= 18 ? 32'(4 * (c - 11)) : 32'h1C);
            if (v) chk("b_data", u, tdata[u], 32'hA000_0000 | 32'(c - 12 - lat[u]));
            chk("b_last", u, 32'(tlast[u]), 32'(c == 19 + lat[u]));
            chk("b_done", u, 32'(done[u]), 32'(c == 20 + lat[u]));
         end
      end

      // Back-pressure: edge at 40, ready low for cycles 45..54.
      go(40);
      gat_ready = 1;
      go(41);
      gat_ready = 0;
      go(45);
      m_tready = 0;
      look(54);
      for (int u = 0; u < 2; u++) begin
         chk("bp_addr", u, 32'(addrb[u]), 32'h14);
         chk("bp_data", u, tdata[u], 32'hA000_0001 + 32'(u));
      end
      go(55);
      m_tready = 1;
      look(55);
      chk("bp_release", 0, tdata[0], 32'hA000_0001);
      look(61);
      chk("bp_done", 1, 32'(done[1]), 32'd1);
      look(62);
      chk("bp_done", 0, 32'(done[0]), 32'd1);

      // Level held high for 100 cycles: one drain only.
      d0 = drains[0];
      d1 = drains[1];
      go(80);
      gat_ready = 1;
      go(180);
      gat_ready = 0;
      look(182);
      chk("hold_one", 0, 32'(drains[0] - d0), 32'd1);
      chk("hold_one", 1, 32'(drains[1] - d1), 32'd1);

      // Second edge while busy is ignored.
      d0 = drains[0];
      d1 = drains[1];
      go(200);
      gat_ready = 1;
      go(201);
      gat_ready = 0;
      go(203);
      gat_ready = 1;
      go(204);
      gat_ready = 0;
      look(230);
      chk("busy_edge", 0, 32'(drains[0] - d0), 32'd1);
      chk("busy_edge", 1, 32'(drains[1] - d1), 32'd1);
      chk("busy_edge_idle", 0, 32'(busy[0] | busy[1]), 32'd0);

      // Random ready, 20 seeds, each a fresh low-to-high edge after done.
      for (int s = 0; s < 20; s++) begin
         d0 = drains[0];
         d1 = drains[1];
         void'($urandom(s * 7 + 3));
         go(cyc + 1);
         gat_ready = 1;
         go(cyc + 1);
         gat_ready = 0;
         wait_done("rand_done", 1'b1);
         chk("rand_drain", 0, 32'(drains[0] - d0), 32'd1);
         chk("rand_drain", 1, 32'(drains[1] - d1), 32'd1);
         go(cyc + 2);
      end

      // Reset after the third handshake of the latency-2 instance.
      t = cyc + 2;
      go(t);
      gat_ready = 1;
      m_tready = 1;
      go(t + 1);
      gat_ready = 0;
      go(t + 7);
      rst = 1;
      go(t + 8);
      rst = 0;
      look(t + 8);
      for (int u = 0; u < 2; u++) begin
         chk("mid_rst_valid", u, 32'(tvalid[u]), 32'd0);
         chk("mid_rst_busy", u, 32'(busy[u]), 32'd0);
         chk("mid_rst_addr", u, 32'(addrb[u]), 32'd0);
      end
      go(t + 12);
      gat_ready = 1;
      go(t + 13);
      gat_ready = 0;
      look(t + 15);
      chk("restart_word0", 1, tdata[1], 32'hA000_0000);
      look(t + 16);
      chk("restart_word0", 0, tdata[0], 32'hA000_0000);
      wait_done("restart_done", 1'b0);

      go(cyc + 3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
